// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write-responder state type.
package axi4_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    WRITE  = 2'd1,
    RESP   = 2'd2
  } t_slv_wr_state;

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Window/alignment check and byte-to-word address translation for an AXI4-Lite responder.
module axi4_lite_addr_decode #(
  parameter int                        AXI_ADDR_WIDTH = 64,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BASE       = '0,
  parameter int unsigned               MEM_SIZE       = 4096,
  parameter int                        MEM_ADDR_WIDTH = $clog2(MEM_SIZE / (AXI_DATA_WIDTH / 8))
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  output logic                      addr_ok_o,
  output logic [MEM_ADDR_WIDTH-1:0] wr_addr_o
);

  localparam int LSB = $clog2(AXI_DATA_WIDTH / 8);
  // One extra bit so a window ending exactly at 2^AXI_ADDR_WIDTH is still representable.
  localparam logic [AXI_ADDR_WIDTH:0] LIMIT = {1'b0, MEM_BASE} + (AXI_ADDR_WIDTH + 1)'(MEM_SIZE);

  generate
    if (LIMIT[AXI_ADDR_WIDTH] && (LIMIT[AXI_ADDR_WIDTH-1:0] != '0)) begin : g_wrap_check
      $error("axi4_lite_addr_decode: MEM_BASE + MEM_SIZE exceeds the address space");
    end
    if ((MEM_SIZE & (MEM_SIZE - 1)) != 0 || MEM_SIZE < (AXI_DATA_WIDTH / 8)) begin : g_size_check
      $error("axi4_lite_addr_decode: MEM_SIZE must be a power of two of at least one word");
    end
  endgenerate

  logic [AXI_ADDR_WIDTH-1:0] offset;
  logic [AXI_ADDR_WIDTH-1:0] word;
  logic                      unused_off;

  assign offset     = addr_i - MEM_BASE;
  assign word       = offset >> LSB;
  assign wr_addr_o  = word[MEM_ADDR_WIDTH-1:0];
  assign unused_off = ^{offset, word};

  assign addr_ok_o = ({1'b0, addr_i} >= {1'b0, MEM_BASE}) &&
                     ({1'b0, addr_i} < LIMIT) &&
                     (addr_i[LSB-1:0] == '0);

endmodule

// File: rtl/axi4_lite_slave_write.sv
// AXI4-Lite write responder: collects AW and W in any order, issues one memory write,
// then holds the B response until accepted.
module axi4_lite_slave_write
  import axi4_lite_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = 64,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BASE       = 64'h0,
  parameter int unsigned               MEM_SIZE       = 4096,
  parameter int                        MEM_ADDR_WIDTH = $clog2(MEM_SIZE / (AXI_DATA_WIDTH / 8))
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        AW_VALID,
  output logic                        AW_READY,
  input  logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
  input  logic [2:0]                  AW_PROT,
  input  logic                        W_VALID,
  output logic                        W_READY,
  input  logic [AXI_DATA_WIDTH-1:0]   W_DATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
  output logic                        B_VALID,
  input  logic                        B_READY,
  output logic [1:0]                  B_RESP,
  output logic                        o_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0]   o_wr_addr,
  output logic [AXI_DATA_WIDTH-1:0]   o_wr_data,
  output logic [AXI_DATA_WIDTH/8-1:0] o_wr_strb
);

  generate
    if (AXI_DATA_WIDTH != 32 && AXI_DATA_WIDTH != 64) begin : g_width_check
      $error("axi4_lite_slave_write: AXI_DATA_WIDTH must be 32 or 64");
    end
  endgenerate

  t_slv_wr_state                 state_q;
  logic                          aw_held_q, w_held_q, b_valid_q;
  logic [1:0]                    b_resp_q;
  logic [AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [2:0]                    prot_q;
  logic [AXI_DATA_WIDTH-1:0]     data_q;
  logic [AXI_DATA_WIDTH/8-1:0]   strb_q;
  logic                          addr_ok, aw_hs, w_hs, unused_prot;

  axi4_lite_addr_decode #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .MEM_BASE       (MEM_BASE),
    .MEM_SIZE       (MEM_SIZE),
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_dec (
    .addr_i    (addr_q),
    .addr_ok_o (addr_ok),
    .wr_addr_o (o_wr_addr)
  );

  assign AW_READY    = (state_q == ACCEPT) && !aw_held_q;
  assign W_READY     = (state_q == ACCEPT) && !w_held_q;
  assign aw_hs       = AW_VALID && AW_READY;
  assign w_hs        = W_VALID && W_READY;
  assign B_VALID     = b_valid_q;
  assign B_RESP      = b_resp_q;
  assign o_wr_en     = (state_q == WRITE) && addr_ok && (|strb_q);
  assign o_wr_data   = data_q;
  assign o_wr_strb   = strb_q;
  assign unused_prot = ^prot_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= ACCEPT;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      b_valid_q <= 1'b0;
      b_resp_q  <= OKAY;
      addr_q    <= '0;
      prot_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (aw_hs) begin
            addr_q    <= AW_ADDR;
            prot_q    <= AW_PROT;
            aw_held_q <= 1'b1;
          end
          if (w_hs) begin
            data_q   <= W_DATA;
            strb_q   <= W_STRB;
            w_held_q <= 1'b1;
          end
          // Beats landing on this same edge count toward completion.
          if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) state_q <= WRITE;
        end
        WRITE: begin
          b_valid_q <= 1'b1;
          b_resp_q  <= addr_ok ? OKAY : SLVERR;
          aw_held_q <= 1'b0;
          w_held_q  <= 1'b0;
          state_q   <= RESP;
        end
        RESP: begin
          if (B_READY) begin
            b_valid_q <= 1'b0;
            state_q   <= ACCEPT;
          end
        end
        default: state_q <= ACCEPT;
      endcase
    end
  end

endmodule
